// File: rtl/circuit_pkg.sv
// Shared definitions for the element scanner: element word layout, type and
// error encodings, FSM state encoding and small node-range helpers.
package circuit_pkg;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int VAL_HI  = 29;
  localparam int VAL_LO  = 20;
  localparam int EXP_HI  = 19;
  localparam int EXP_LO  = 16;
  localparam int NA_HI   = 7;
  localparam int NA_LO   = 4;
  localparam int NB_HI   = 3;
  localparam int NB_LO   = 0;

  typedef enum logic [1:0] {
    TYPE_RES  = 2'd0,
    TYPE_VSRC = 2'd1,
    TYPE_ISRC = 2'd2,
    TYPE_RSVD = 2'd3
  } elem_type_e;

  typedef struct packed {
    elem_type_e  etype;
    logic [9:0]  value;
    logic [3:0]  exponent;
    logic [3:0]  node_a;
    logic [3:0]  node_b;
  } elem_fields_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_EMPTY     = 3'd1;
  localparam logic [2:0] ERR_SELF_LOOP = 3'd2;
  localparam logic [2:0] ERR_RSVD_TYPE = 3'd3;
  localparam logic [2:0] ERR_FLOATING  = 3'd4;
  localparam logic [2:0] ERR_NO_GROUND = 3'd5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_EVAL    = 3'd4;
  localparam logic [2:0] ST_NODECHK = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // Number of node slots an element touches: highest node index + 1.
  function automatic logic [4:0] node_span(input logic [3:0] a, input logic [3:0] b);
    if (a > b) begin
      return {1'b0, a} + 5'd1;
    end else begin
      return {1'b0, b} + 5'd1;
    end
  endfunction

  function automatic logic [15:0] below_mask(input logic [4:0] n);
    logic [15:0] m;
    m = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_elements_if.sv
// Handshake and element-RAM bus between the upstream stage and the scanner.
interface scan_elements_if;
  logic        start_process;
  logic        end_process;
  logic [4:0]  numElements;
  logic [4:0]  element_addr;
  logic [31:0] element_q;
  logic [4:0]  num_nodes;
  logic [4:0]  num_res;
  logic [4:0]  num_vsrc;
  logic [4:0]  num_isrc;
  logic [2:0]  error_code;
  logic [4:0]  error_addr;

  modport master (
    output start_process, numElements, element_q,
    input  end_process, element_addr, num_nodes, num_res, num_vsrc, num_isrc,
           error_code, error_addr
  );

  modport slave (
    input  start_process, numElements, element_q,
    output end_process, element_addr, num_nodes, num_res, num_vsrc, num_isrc,
           error_code, error_addr
  );
endinterface

// File: rtl/element_decode.sv
// Pure combinational unpacking of one 32-bit element word into its fields.
module element_decode
  import circuit_pkg::*;
(
  input  logic [31:0]  word,
  output elem_fields_t fields
);

  logic unused_bits_s;
  assign unused_bits_s = ^word[15:8];

  // Field extraction
  always_comb begin
    fields.etype    = elem_type_e'(word[TYPE_HI:TYPE_LO]);
    fields.value    = word[VAL_HI:VAL_LO];
    fields.exponent = word[EXP_HI:EXP_LO];
    fields.node_a   = word[NA_HI:NA_LO];
    fields.node_b   = word[NB_HI:NB_LO];
  end

endmodule

// File: rtl/scan_elements.sv
// Walks the element RAM, counting element types and the node range, and stops
// at the first malformed element. Define SCAN_ELEMENTS_NODE_CHECK_EN to add the
// floating-node / missing-ground check after the walk.
module scan_elements
  import circuit_pkg::*;
(
  input logic            clk,
  input logic            program_resetn,
  scan_elements_if.slave bus
);

  logic [2:0]  state_r;
  logic        end_r;
  logic [4:0]  addr_r;
  logic [4:0]  nodes_r;
  logic [4:0]  res_r;
  logic [4:0]  vsrc_r;
  logic [4:0]  isrc_r;
  logic [2:0]  err_r;
  logic [4:0]  err_addr_r;
  logic [31:0] elem_q_r;
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
  logic [15:0] seen_r;
`endif

  elem_fields_t fld_s;
  logic [2:0]   eval_err_s;
  logic [4:0]   span_s;
  logic         last_s;
  logic         unused_fields_s;

  element_decode u_decode (
    .word   (elem_q_r),
    .fields (fld_s)
  );

  assign unused_fields_s = ^{fld_s.value, fld_s.exponent};

  assign bus.end_process  = end_r;
  assign bus.element_addr = addr_r;
  assign bus.num_nodes    = nodes_r;
  assign bus.num_res      = res_r;
  assign bus.num_vsrc     = vsrc_r;
  assign bus.num_isrc     = isrc_r;
  assign bus.error_code   = err_r;
  assign bus.error_addr   = err_addr_r;

  // Classify the latched element; self-loop takes precedence over reserved type
  always_comb begin
    eval_err_s = ERR_NONE;
    if (fld_s.node_a == fld_s.node_b) begin
      eval_err_s = ERR_SELF_LOOP;
    end else if (fld_s.etype == TYPE_RSVD) begin
      eval_err_s = ERR_RSVD_TYPE;
    end else begin
      eval_err_s = ERR_NONE;
    end
    span_s = node_span(fld_s.node_a, fld_s.node_b);
    last_s = ({1'b0, addr_r} + 6'd1) >= {1'b0, bus.numElements};
  end

  // Scan FSM and result registers
  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state_r    <= ST_IDLE;
      end_r      <= 1'b0;
      addr_r     <= 5'd0;
      nodes_r    <= 5'd0;
      res_r      <= 5'd0;
      vsrc_r     <= 5'd0;
      isrc_r     <= 5'd0;
      err_r      <= ERR_NONE;
      err_addr_r <= 5'd0;
      elem_q_r   <= 32'd0;
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
      seen_r     <= 16'd0;
`endif
    end else if (!bus.start_process && (state_r != ST_IDLE)) begin
      // Request withdrawn: abandon the scan (or leave DONE) on this edge
      state_r <= ST_IDLE;
      end_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          end_r <= 1'b0;
          if (bus.start_process) begin
            state_r <= ST_INIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INIT: begin
          addr_r     <= 5'd0;
          nodes_r    <= 5'd0;
          res_r      <= 5'd0;
          vsrc_r     <= 5'd0;
          isrc_r     <= 5'd0;
          err_addr_r <= 5'd0;
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
          seen_r     <= 16'd0;
`endif
          if (bus.numElements == 5'd0) begin
            err_r   <= ERR_EMPTY;
            end_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            err_r   <= ERR_NONE;
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          elem_q_r <= bus.element_q;
          state_r  <= ST_EVAL;
        end
        ST_EVAL: begin
          if (eval_err_s != ERR_NONE) begin
            err_r      <= eval_err_s;
            err_addr_r <= addr_r;
            end_r      <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            case (fld_s.etype)
              TYPE_RES:  res_r  <= res_r + 5'd1;
              TYPE_VSRC: vsrc_r <= vsrc_r + 5'd1;
              TYPE_ISRC: isrc_r <= isrc_r + 5'd1;
              default:   res_r  <= res_r;
            endcase
            if (span_s > nodes_r) begin
              nodes_r <= span_s;
            end else begin
              nodes_r <= nodes_r;
            end
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
            seen_r <= seen_r | (16'd1 << fld_s.node_a) | (16'd1 << fld_s.node_b);
`endif
            if (!last_s) begin
              addr_r  <= addr_r + 5'd1;
              state_r <= ST_READ;
            end else begin
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
              state_r <= ST_NODECHK;
`else
              end_r   <= 1'b1;
              state_r <= ST_DONE;
`endif
            end
          end
        end
`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
        ST_NODECHK: begin
          if (!seen_r[0]) begin
            err_r <= ERR_NO_GROUND;
          end else if ((~seen_r & below_mask(nodes_r)) != 16'd0) begin
            err_r <= ERR_FLOATING;
          end else begin
            err_r <= ERR_NONE;
          end
          end_r   <= 1'b1;
          state_r <= ST_DONE;
        end
`endif
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          end_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_elements.sv
// Directed self-checking bench for scan_elements; expected values are hand
// computed for both the default build and SCAN_ELEMENTS_NODE_CHECK_EN.
module tb_scan_elements;
  import circuit_pkg::*;

`ifdef SCAN_ELEMENTS_NODE_CHECK_EN
  localparam int NC = 1;
`else
  localparam int NC = 0;
`endif

  logic clk = 1'b0;
  logic program_resetn;
  logic [31:0] mem [0:31];
  int total = 0;
  int bad = 0;
  int lat;

  always #5 clk = ~clk;

  scan_elements_if bus ();

  scan_elements dut (
    .clk            (clk),
    .program_resetn (program_resetn),
    .bus            (bus)
  );

  always @(posedge clk) bus.element_q <= mem[bus.element_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b);
    return {t, 10'd517, 4'd9, 8'hA5, a, b};
  endfunction

  task automatic start_scan(input int n);
    @(negedge clk);
    bus.numElements   = n[4:0];
    bus.start_process = 1'b1;
  endtask

  task automatic wait_end(output int l);
    l = -1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.end_process) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic stop_scan(input string tag);
    @(negedge clk);
    bus.start_process = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_end_low"}, 32'(bus.end_process), 32'd0);
  endtask

  task automatic check_res(input string tag, input int nodes, input int res, input int vs,
                           input int is, input int code, input int eaddr);
    check_val({tag, "_nodes"}, 32'(bus.num_nodes), nodes);
    check_val({tag, "_res"},   32'(bus.num_res), res);
    check_val({tag, "_vsrc"},  32'(bus.num_vsrc), vs);
    check_val({tag, "_isrc"},  32'(bus.num_isrc), is);
    check_val({tag, "_code"},  32'(bus.error_code), code);
    check_val({tag, "_eaddr"}, 32'(bus.error_addr), eaddr);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    bus.start_process = 1'b0;
    bus.numElements   = 5'd0;
    program_resetn    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_end", 32'(bus.end_process), 32'd0);
    check_val("rst_addr", 32'(bus.element_addr), 32'd0);
    check_res("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    program_resetn = 1'b1;

    // Empty element list
    start_scan(0);
    wait_end(lat);
    check_val("empty_lat", 32'(lat), 32'd1);
    check_res("empty", 0, 0, 0, 0, 1, 0);
    stop_scan("empty");

    // Basic three-element circuit, then hold and retain behaviour
    mem[0] = mk(2'd0, 4'd0, 4'd1);
    mem[1] = mk(2'd1, 4'd1, 4'd0);
    mem[2] = mk(2'd0, 4'd1, 4'd2);
    start_scan(3);
    wait_end(lat);
    check_val("basic_lat", 32'(lat), 32'(10 + NC));
    check_res("basic", 3, 2, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check_val("basic_hold_end", 32'(bus.end_process), 32'd1);
    check_val("basic_hold_res", 32'(bus.num_res), 32'd2);
    stop_scan("basic");
    check_val("basic_retain_res", 32'(bus.num_res), 32'd2);
    check_val("basic_retain_nodes", 32'(bus.num_nodes), 32'd3);

    // Self-loop at address 2
    mem[0] = mk(2'd0, 4'd0, 4'd1);
    mem[1] = mk(2'd2, 4'd1, 4'd2);
    mem[2] = mk(2'd1, 4'd4, 4'd4);
    mem[3] = mk(2'd0, 4'd5, 4'd6);
    start_scan(4);
    wait_end(lat);
    check_val("loop_lat", 32'(lat), 32'd10);
    check_res("loop", 3, 1, 0, 1, 2, 2);
    stop_scan("loop");

    // Reserved type at address 1
    mem[0] = mk(2'd0, 4'd2, 4'd3);
    mem[1] = mk(2'd3, 4'd0, 4'd2);
    mem[2] = mk(2'd0, 4'd0, 4'd1);
    start_scan(3);
    wait_end(lat);
    check_val("rsvd_lat", 32'(lat), 32'd7);
    check_res("rsvd", 4, 1, 0, 0, 3, 1);
    stop_scan("rsvd");

    // Node 2 never referenced
    mem[0] = mk(2'd0, 4'd0, 4'd1);
    mem[1] = mk(2'd0, 4'd1, 4'd3);
    start_scan(2);
    wait_end(lat);
    check_val("float_lat", 32'(lat), 32'(7 + NC));
    check_res("float", 4, 2, 0, 0, (NC == 1) ? 4 : 0, 0);
    stop_scan("float");

    // Ground node unused
    mem[0] = mk(2'd0, 4'd1, 4'd2);
    start_scan(1);
    wait_end(lat);
    check_val("gnd_lat", 32'(lat), 32'(4 + NC));
    check_res("gnd", 3, 1, 0, 0, (NC == 1) ? 5 : 0, 0);
    stop_scan("gnd");

    // Start withdrawn mid-scan, then a fresh scan
    mem[0] = mk(2'd0, 4'd0, 4'd1);
    mem[1] = mk(2'd1, 4'd1, 4'd0);
    mem[2] = mk(2'd0, 4'd1, 4'd2);
    start_scan(3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start_process = 1'b0;
    @(posedge clk);
    #1;
    check_val("drop_end", 32'(bus.end_process), 32'd0);
    check_val("drop_state", 32'(dut.state_r), 32'(ST_IDLE));
    mem[0] = mk(2'd2, 4'd0, 4'd5);
    mem[1] = mk(2'd2, 4'd5, 4'd0);
    start_scan(2);
    wait_end(lat);
    check_val("restart_lat", 32'(lat), 32'(7 + NC));
    check_res("restart", 6, 0, 0, 2, 0, 0);
    stop_scan("restart");

    // Reset while latching element 2
    mem[0] = mk(2'd0, 4'd0, 4'd1);
    mem[1] = mk(2'd1, 4'd1, 4'd0);
    mem[2] = mk(2'd0, 4'd1, 4'd2);
    start_scan(3);
    repeat (9) @(posedge clk);
    #2;
    check_val("prerst_state", 32'(dut.state_r), 32'(ST_LATCH));
    check_val("prerst_addr", 32'(bus.element_addr), 32'd2);
    check_val("prerst_res", 32'(bus.num_res), 32'd1);
    program_resetn = 1'b0;
    #1;
    check_val("midrst_state", 32'(dut.state_r), 32'(ST_IDLE));
    check_val("midrst_end", 32'(bus.end_process), 32'd0);
    check_val("midrst_addr", 32'(bus.element_addr), 32'd0);
    check_res("midrst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.start_process = 1'b0;
    program_resetn    = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_elements.md
SCAN_ELEMENTS -- requirements
Module: scan_elements

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port program_resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start_process, input, 1 bit: level request, driven by upstream element-entry stage completion.
REQ-004 SHALL have port end_process, output, 1 bit: scan complete, results valid.
REQ-005 SHALL have port numElements, input, 5 bits: count of stored elements (0..31).
REQ-006 SHALL have port element_addr, output, 5 bits: element RAM read address.
REQ-007 SHALL have port element_q, input, 32 bits: element RAM read data, 1-cycle latency after address.
REQ-008 SHALL have port num_nodes, output, 5 bits: highest node index referenced + 1.
REQ-009 SHALL have ports num_res, num_vsrc and num_isrc, output, 5 bits each: per-type element counts.
REQ-010 SHALL have port error_code, output, 3 bits: 0 none, 1 empty, 2 self-loop, 3 reserved type, 4 floating node, 5 no ground.
REQ-011 SHALL have port error_addr, output, 5 bits: address of the first offending element (0 for codes 1, 4 and 5).

Function
REQ-012 SHALL decode each element word as type[31:30] (0 resistor, 1 V-source, 2 I-source, 3 reserved), value[29:20], exponent[19:16], node_a[7:4], node_b[3:0]; bits [15:8] are ignored.
REQ-013 SHALL implement states IDLE, INIT, READ, LATCH, EVAL, NODECHK (macro only) and DONE.
REQ-014 SHALL move IDLE->INIT when start_process=1; INIT clears the counters, the max-node register, the seen-mask and the error outputs, and sets element_addr=0.
REQ-015 SHALL move INIT->DONE with error_code=1 when numElements=0; otherwise INIT->READ.
REQ-016 SHALL drive element_addr in READ, register element_q in LATCH, and update the results in EVAL (3 cycles per element).
REQ-017 SHALL, in EVAL, increment the counter for the element's type, and update num_nodes to max(num_nodes, max(node_a,node_b)+1).
REQ-018 SHALL, in EVAL, stop at the first error: node_a==node_b sets code 2; type=3 sets code 3; error_addr is set to the current address and the next state is DONE.
REQ-019 SHALL, in EVAL with no error, increment element_addr and go to READ while addr+1 < numElements; otherwise go to NODECHK (macro) or DONE.
REQ-020 SHALL have end-to-end latency: start sampled at edge k gives end_process=1 after edge k+1+3N (k+2+3N with macro), N = numElements.
REQ-021 SHALL hold end_process=1 and all results stable in DONE while start_process=1, and return to IDLE when start_process=0; results are retained until the next INIT.
REQ-022 SHALL, when start_process falls during INIT through NODECHK, go to IDLE on the next edge with end_process=0; results are then undefined until the next scan.
REQ-023 SHALL never write the element RAM; element_addr SHALL hold its value outside READ.

Reset
REQ-024 SHALL, on program_resetn=0, immediately force IDLE, end_process=0, element_addr=0, and all counts, num_nodes, error_code, error_addr and the seen-mask to 0, including mid-scan.

Configuration
REQ-025 SHALL, when SCAN_ELEMENTS_NODE_CHECK_EN is defined, keep a 16-bit seen-mask set from node_a/node_b in EVAL.
REQ-026 SHALL, with that macro defined, run NODECHK for 1 cycle: mask bit 0 clear gives code 5; otherwise any clear bit below num_nodes gives code 4; then DONE.
REQ-027 SHALL, without that macro, omit the seen-mask and the NODECHK state; codes 4 and 5 never occur.

Structure
REQ-028 SHALL place the element field bit positions, the type encodings, the error codes and the state encoding in the shared package circuit_pkg.
REQ-029 SHALL use one combinational sub-module, element_decode, that unpacks element_q into its fields.

Verification
REQ-030 SHALL cover: numElements=0 and start=1 -> end_process after 1 cycle, error_code=1, all counts 0.
REQ-031 SHALL cover: 3 elements {R 0-1, V 1-0, R 1-2} -> num_res=2, num_vsrc=1, num_nodes=3, code 0, end after 10 cycles (11 with macro).
REQ-032 SHALL cover: element 2 with node_a=node_b=4 -> code 2, error_addr=2, counts reflect elements 0-1 only.
REQ-033 SHALL cover: with the macro, {R 0-1, R 1-3} -> code 4; {R 1-2} -> code 5; without the macro both cases -> code 0.
REQ-034 SHALL cover: start dropped mid-scan -> IDLE next edge, end_process=0; a restart then gives correct fresh results.
REQ-035 SHALL cover: program_resetn asserted in LATCH -> all outputs 0 immediately, state IDLE.
